adc_capture_ctrl: RTL and testbench



---
 rtl/adc_cap_pkg.sv | 17 +
 rtl/adc_cap_ram.sv | 33 +++
 rtl/adc_capture_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_cap_pkg.sv
// Shared types for the ADC capture controller: FSM state encoding and
// trigger-mode codes.
package adc_cap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT,
    POST,
    DONE
  } cap_state_e;

  localparam logic [1:0] TRIG_RISE = 2'b00;
  localparam logic [1:0] TRIG_FALL = 2'b01;
  localparam logic [1:0] TRIG_IMM  = 2'b10;

endpackage

// File: rtl/adc_cap_ram.sv
// Simple dual-port sample RAM: one write port and one registered read port.
// The read register is cleared by reset; the array itself is never cleared.
module adc_cap_ram #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port; holds its value when no read is requested
  always_ff @(posedge clk) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: samples ad_data_in on each sample_sig rising edge
// into a circular buffer, keeps pre_len samples ahead of the trigger and
// offers a trigger-aligned readout once the record is complete.
// Optional macro TRIG_TIMEOUT_EN adds a forced trigger after TMO_SAMPLES
// WAIT samples without a trigger.
module adc_capture_ctrl
  import adc_cap_pkg::*;
#(
  parameter int unsigned DATA_W      = 10,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TMO_SAMPLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ad_data_in,
  input  logic              sample_sig,
  input  logic              arm,
  input  logic [1:0]        trig_mode,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              timed_out
);

  cap_state_e        r_state, w_state_nxt;
  logic [1:0]        r_sync;
  logic              r_sync_d;
  logic              w_se;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_level;
  logic [ADDR_W-1:0] r_pre_len;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_wptr;
  logic [DATA_W-1:0] r_prev;
  logic              r_prev_valid;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              w_start, w_wr, w_trig, w_hit, w_force;
  logic              w_rd_ok;
  logic [ADDR_W-1:0] w_raddr;

  // Two-stage synchroniser plus edge detector for the slow sample strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], sample_sig};
      r_sync_d <= r_sync[1];
    end
  end

  assign w_se = r_sync[1] & ~r_sync_d;

  // Trigger condition for the sample currently being written
  always_comb begin
    w_hit = 1'b1;
    unique case (r_mode)
      TRIG_RISE: w_hit = r_prev_valid && (r_prev < r_level) && (ad_data_in >= r_level);
      TRIG_FALL: w_hit = r_prev_valid && (r_prev > r_level) && (ad_data_in <= r_level);
      default:   w_hit = 1'b1;
    endcase
  end

`ifdef TRIG_TIMEOUT_EN
  localparam int unsigned       TMO_W    = $clog2(TMO_SAMPLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_SAMPLES - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timed_out;

  // Count WAIT samples that did not trigger; flag forced triggers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo_cnt   <= '0;
      r_timed_out <= 1'b0;
    end else if (w_start) begin
      r_tmo_cnt   <= '0;
      r_timed_out <= 1'b0;
    end else if (w_trig) begin
      r_timed_out <= ~w_hit;
    end else if (r_state == WAIT && w_se) begin
      r_tmo_cnt   <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_force   = (r_tmo_cnt == TMO_LAST);
  assign timed_out = r_timed_out;
`else
  assign w_force   = 1'b0;
  assign timed_out = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and per-cycle write/trigger strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_wr        = 1'b0;
    w_trig      = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (arm) begin
          w_start     = 1'b1;
          w_state_nxt = (pre_len == '0) ? WAIT : PRE;
        end
      end
      PRE: begin
        if (w_se) begin
          w_wr = 1'b1;
          if (r_cnt == ADDR_W'(1)) w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_se) begin
          w_wr = 1'b1;
          if (w_hit || w_force) begin
            w_trig      = 1'b1;
            // Post count DEPTH-pre_len-1 is ~pre_len; zero only when pre_len is all ones
            w_state_nxt = (r_pre_len == '1) ? DONE : POST;
          end
        end
      end
      POST: begin
        if (w_se) begin
          w_wr = 1'b1;
          if (r_cnt == ADDR_W'(1)) w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture settings, write pointer, sample history and PRE/POST counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode       <= TRIG_RISE;
      r_level      <= '0;
      r_pre_len    <= '0;
      r_cnt        <= '0;
      r_wptr       <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_trig_addr  <= '0;
    end else begin
      if (w_start) begin
        r_mode       <= trig_mode;
        r_level      <= trig_level;
        r_pre_len    <= pre_len;
        r_cnt        <= pre_len;
        r_prev_valid <= 1'b0;
      end
      if (w_wr) begin
        r_wptr       <= r_wptr + 1'b1;
        r_prev       <= ad_data_in;
        r_prev_valid <= 1'b1;
        if (r_state != WAIT) r_cnt <= r_cnt - 1'b1;
      end
      if (w_trig) begin
        r_trig_addr <= r_wptr;
        r_cnt       <= ~r_pre_len;
      end
    end
  end

  assign w_rd_ok = rd_en && (r_state == IDLE || r_state == DONE);
  assign w_raddr = r_trig_addr - r_pre_len + rd_addr;

  adc_cap_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr),
    .i_waddr (r_wptr),
    .i_wdata (ad_data_in),
    .i_re    (w_rd_ok),
    .i_raddr (w_raddr),
    .o_rdata (rd_data)
  );

  assign busy      = (r_state == PRE) || (r_state == WAIT) || (r_state == POST);
  assign done      = (r_state == DONE);
  assign trig_addr = r_trig_addr;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl (DATA_W=10, ADDR_W=4, TMO_SAMPLES=8).
// Expected records come from a sample-list model: the trigger index is found
// from the trigger rules, then each sample's physical address follows from
// the write pointer at arm time.
module tb_adc_capture_ctrl;

  localparam int DEPTH = 16;
  localparam int TMO   = 8;
`ifdef TRIG_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] ad_data_in = '0;
  logic       sample_sig = 1'b0;
  logic       arm = 1'b0;
  logic [1:0] trig_mode = '0;
  logic [9:0] trig_level = '0;
  logic [3:0] pre_len = '0;
  logic       rd_en = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [9:0] rd_data;
  logic       busy, done, timed_out;
  logic [3:0] trig_addr;

  adc_capture_ctrl #(
    .DATA_W      (10),
    .ADDR_W      (4),
    .TMO_SAMPLES (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ad_data_in (ad_data_in),
    .sample_sig (sample_sig),
    .arm        (arm),
    .trig_mode  (trig_mode),
    .trig_level (trig_level),
    .pre_len    (pre_len),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .trig_addr  (trig_addr),
    .timed_out  (timed_out)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  int m_mem [DEPTH];
  bit m_known [DEPTH];
  int m_wp = 0, m_trig = 0, m_start = 0;
  bit m_to = 1'b0, m_valid = 1'b0;

  // Read request handshake between reader task and compare process
  int rd_seq = 0, seen_seq = 0, rd_exp = 0;
  bit rd_known = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare process: per-cycle checks against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_and_done", int'(busy && done), 0);
      if (done && m_valid) begin
        chk("trig_addr", int'(trig_addr), m_trig);
        chk("timed_out", int'(timed_out), int'(m_to));
      end
      if (!TMO_EN) chk("timed_out_tied", int'(timed_out), 0);
      if (rd_seq != seen_seq) begin
        seen_seq = rd_seq;
        if (rd_known) chk("rd_data_model", int'(rd_data), rd_exp);
      end
    end
  end

  // Trigger index t, forced flag and total write count for a sample list
  function automatic void plan(input int q[$], input int mode, input int lvl, input int pre,
                               output int t, output bit to, output int total);
    int wcnt;
    bit hit;
    wcnt = 0; t = -1; to = 1'b0; total = 0;
    for (int i = pre; i < q.size(); i++) begin
      if (mode >= 2)      hit = 1'b1;
      else if (i == 0)    hit = 1'b0;
      else if (mode == 0) hit = (q[i-1] < lvl) && (q[i] >= lvl);
      else                hit = (q[i-1] > lvl) && (q[i] <= lvl);
      wcnt++;
      if (hit || (TMO_EN && wcnt == TMO)) begin
        t = i; to = !hit; total = i + DEPTH - pre;
        return;
      end
    end
  endfunction

  task automatic send_sample(input int v);
    ad_data_in = v[9:0];
    sample_sig = 1'b1;
    #500;
    sample_sig = 1'b0;
    #500;
  endtask

  task automatic rd_idx(input int i, output int got);
    int phys;
    @(negedge clk);
    rd_en = 1'b1;
    rd_addr = i[3:0];
    phys = (m_start + i) % DEPTH;
    rd_exp = m_mem[phys];
    rd_known = m_known[phys];
    @(posedge clk);
    #1 rd_en = 1'b0;
    rd_seq++;
    @(negedge clk);
    got = int'(rd_data);
  endtask

  task automatic read_record();
    int g;
    for (int i = 0; i < DEPTH; i++) rd_idx(i, g);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_trig_addr", int'(trig_addr), 0);
    rst_n = 1'b1;
    m_wp = 0; m_start = 0; m_valid = 1'b0;
  endtask

  task automatic capture(input string tag, input int mode, input int lvl, input int pre,
                         input int q[$], input int stop_after, input int arm_at);
    int t, total, n, wp0;
    bit to;
    plan(q, mode, lvl, pre, t, to, total);
    if (t < 0 || total > q.size()) begin
      checks++; errors++;
      $display("FAIL %s_plan: got no trigger in stimulus, required one", tag);
      return;
    end
    @(negedge clk);
    trig_mode = mode[1:0]; trig_level = lvl[9:0]; pre_len = pre[3:0]; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    wp0 = m_wp;
    m_trig = (wp0 + t) % DEPTH;
    m_start = (m_trig - pre + DEPTH) % DEPTH;
    m_to = to; m_valid = 1'b1;
    chk({tag, "_busy_after_arm"}, int'(busy), 1);
    chk({tag, "_done_after_arm"}, int'(done), 0);
    n = (stop_after >= 0) ? stop_after : total;
    for (int k = 0; k < n; k++) begin
      if (k == total - 1) chk({tag, "_done_early"}, int'(done), 0);
      if (k == arm_at) begin
        @(negedge clk);
        trig_mode = 2'b10; pre_len = '0; arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk({tag, "_arm_ignored"}, int'(busy), 1);
      end
      send_sample(q[k]);
      m_mem[(wp0 + k) % DEPTH] = q[k];
      m_known[(wp0 + k) % DEPTH] = 1'b1;
    end
    if (stop_after >= 0) begin
      do_reset();
    end else begin
      m_wp = (wp0 + total) % DEPTH;
      chk({tag, "_done"}, int'(done), 1);
      chk({tag, "_busy_end"}, int'(busy), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int g;
    int q[$];
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 0; m_known[i] = 1'b0; end

    // Reset state
    repeat (5) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_trig_addr", int'(trig_addr), 0);
    rst_n = 1'b1;
    repeat (3) send_sample(777);
    chk("idle_busy", int'(busy), 0);

    // Rising trigger
    q.delete();
    for (int k = 0; k < 40; k++) q.push_back(60 + 5 * k);
    capture("rise", 0, 100, 4, q, -1, -1);
    chk("rise_trig_addr_lit", int'(trig_addr), 8);
    read_record();
    rd_idx(0, g);  chk("rise_idx0", g, 80);
    rd_idx(3, g);  chk("rise_idx3", g, 95);
    rd_idx(4, g);  chk("rise_idx4", g, 100);
    rd_idx(15, g); chk("rise_idx15", g, 155);

    // Reset keeps RAM; idle samples are not written
    do_reset();
    repeat (2) send_sample(999);
    read_record();
    rd_idx(0, g); chk("ram_kept_phys0", g, 140);
    rd_idx(4, g); chk("ram_kept_phys4", g, 80);

    // Falling trigger
    q.delete();
    for (int k = 0; k < 45; k++) q.push_back(80 - 2 * k);
    capture("fall", 1, 50, 2, q, -1, -1);
    chk("fall_trig_addr_lit", int'(trig_addr), 15);
    read_record();
    rd_idx(0, g);  chk("fall_idx0", g, 54);
    rd_idx(2, g);  chk("fall_idx2", g, 50);
    rd_idx(15, g); chk("fall_idx15", g, 24);

    // Immediate, pre_len 0
    q.delete();
    for (int k = 0; k < 20; k++) q.push_back(300 + 3 * k);
    capture("imm", 2, 0, 0, q, -1, -1);
    chk("imm_trig_addr_lit", int'(trig_addr), 13);
    read_record();
    rd_idx(0, g);  chk("imm_idx0", g, 300);
    rd_idx(15, g); chk("imm_idx15", g, 345);

    // Mode 3 behaves as immediate
    q.delete();
    for (int k = 0; k < 20; k++) q.push_back(500 + k);
    capture("mode3", 3, 0, 5, q, -1, -1);
    chk("mode3_trig_addr_lit", int'(trig_addr), 2);
    read_record();
    rd_idx(5, g); chk("mode3_idx5", g, 505);

    // Arm while busy is ignored
    q.delete();
    for (int k = 0; k < 30; k++) q.push_back(90 + 2 * k);
    capture("busyarm", 0, 100, 3, q, -1, 10);
    chk("busyarm_trig_addr_lit", int'(trig_addr), 2);
    read_record();
    rd_idx(0, g); chk("busyarm_idx0", g, 94);
    rd_idx(3, g); chk("busyarm_idx3", g, 100);

    // Reset mid-POST, then a fresh immediate record
    q.delete();
    for (int k = 0; k < 20; k++) q.push_back(600 + k);
    capture("midrst", 2, 0, 0, q, 8, -1);
    q.delete();
    for (int k = 0; k < 20; k++) q.push_back(700 + k);
    capture("rearm", 2, 0, 0, q, -1, -1);
    chk("rearm_trig_addr_lit", int'(trig_addr), 0);
    read_record();
    rd_idx(0, g);  chk("rearm_idx0", g, 700);
    rd_idx(15, g); chk("rearm_idx15", g, 715);

`ifdef TRIG_TIMEOUT_EN
    // Forced trigger on the 8th WAIT sample
    q.delete();
    for (int k = 0; k < 30; k++) q.push_back(10);
    capture("tmo", 0, 100, 2, q, -1, -1);
    chk("tmo_timed_out_lit", int'(timed_out), 1);
    chk("tmo_trig_addr_lit", int'(trig_addr), 9);
    read_record();
    q.delete();
    for (int k = 0; k < 20; k++) q.push_back(40 + k);
    capture("tmo_clear", 2, 0, 0, q, -1, -1);
    chk("tmo_cleared_lit", int'(timed_out), 0);
`endif

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
